// File: rtl/keypad_pin_collector.sv
// +-----------------------------------------------------------------------------+
// | keypad_pin_collector : gathers keypad digits into a 4-digit BCD PIN         |
// | Revision 1.0                                                                 |
// +-----------------------------------------------------------------------------+
`default_nettype none

module keypad_pin_collector #(
  parameter int ACK_HOLD       = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit AUTO_SUBMIT    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        entry_enable,
  input  logic        key_valid,
  input  logic [3:0]  key_value,
  output logic [15:0] code,
  output logic        code_ack,
  output logic [2:0]  digit_count,
  output logic        key_reject,
  output logic        timeout_flag
);

  localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = (ACK_HOLD < 1) ? 1 : $clog2(ACK_HOLD + 1);

  localparam logic [TW-1:0] C_TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW-1:0] C_ACK_LAST = AW'(ACK_HOLD);
  localparam logic [3:0]    C_KEY_CLR  = 4'hC;
  localparam logic [3:0]    C_KEY_ENT  = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ACK     = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [15:0]   code_nx;
  logic [2:0]    count_nx;
  logic          ack_nx;
  logic          reject_nx;
  logic          tflag_nx;
  logic [TW-1:0] to_cnt, to_cnt_nx;
  logic [AW-1:0] ack_cnt, ack_cnt_nx;

  logic is_digit;
  logic is_clear;
  logic is_enter;

  assign is_digit = (key_value <= 4'd9);
  assign is_clear = (key_value == C_KEY_CLR);
  assign is_enter = (key_value == C_KEY_ENT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      code         <= 16'h0000;
      code_ack     <= 1'b0;
      digit_count  <= 3'd0;
      key_reject   <= 1'b0;
      timeout_flag <= 1'b0;
      to_cnt       <= '0;
      ack_cnt      <= '0;
    end else begin
      state        <= state_nx;
      code         <= code_nx;
      code_ack     <= ack_nx;
      digit_count  <= count_nx;
      key_reject   <= reject_nx;
      timeout_flag <= tflag_nx;
      to_cnt       <= to_cnt_nx;
      ack_cnt      <= ack_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    code_nx    = code;
    count_nx   = digit_count;
    ack_nx     = 1'b0;
    reject_nx  = 1'b0;
    tflag_nx   = 1'b0;
    to_cnt_nx  = to_cnt;
    ack_cnt_nx = ack_cnt;

    case (state)
      IDLE: begin
        to_cnt_nx  = '0;
        ack_cnt_nx = '0;
        if (entry_enable && key_valid) begin
          if (is_digit) begin
            // A fresh entry always starts from an all-zero code.
            state_nx = COLLECT;
            code_nx  = {12'h000, key_value};
            count_nx = 3'd1;
          end else if (!is_clear) begin
            reject_nx = 1'b1;
          end
        end
      end

      COLLECT: begin
        if (!entry_enable) begin
          state_nx  = IDLE;
          code_nx   = 16'h0000;
          count_nx  = 3'd0;
          to_cnt_nx = '0;
        end else if (key_valid) begin
          to_cnt_nx = '0;
          if (is_digit) begin
            if (digit_count < 3'd4) begin
              code_nx  = {code[11:0], key_value};
              count_nx = digit_count + 3'd1;
              if (AUTO_SUBMIT && (digit_count == 3'd3)) begin
                state_nx   = ACK;
                ack_nx     = 1'b1;
                ack_cnt_nx = AW'(1);
              end
            end else begin
              reject_nx = 1'b1;
            end
          end else if (is_clear) begin
            code_nx  = 16'h0000;
            count_nx = 3'd0;
          end else if (is_enter && (digit_count == 3'd4)) begin
            state_nx   = ACK;
            ack_nx     = 1'b1;
            ack_cnt_nx = AW'(1);
          end else begin
            reject_nx = 1'b1;
          end
        end else if (digit_count != 3'd0) begin
          // A key on the expiry cycle takes the branch above, so it wins.
          if (to_cnt == C_TO_LAST) begin
            state_nx  = IDLE;
            code_nx   = 16'h0000;
            count_nx  = 3'd0;
            tflag_nx  = 1'b1;
            to_cnt_nx = '0;
          end else begin
            to_cnt_nx = to_cnt + TW'(1);
          end
        end else begin
          to_cnt_nx = '0;
        end
      end

      ACK: begin
        to_cnt_nx = '0;
        reject_nx = key_valid;
        if (ack_cnt == C_ACK_LAST) begin
          state_nx   = IDLE;
          count_nx   = 3'd0;
          ack_cnt_nx = '0;
        end else begin
          ack_nx     = 1'b1;
          ack_cnt_nx = ack_cnt + AW'(1);
        end
      end

      default: begin
        state_nx   = IDLE;
        code_nx    = 16'h0000;
        count_nx   = 3'd0;
        to_cnt_nx  = '0;
        ack_cnt_nx = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_keypad_pin_collector.sv
// Directed bench for keypad_pin_collector: two instances cover the
// enter-key and auto-submit configurations; acked codes are scoreboarded.
`default_nettype none

module tb_keypad_pin_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        en_a = 1'b0, kv_a = 1'b0;
  logic [3:0]  kval_a = 4'h0;
  logic [15:0] code_a;
  logic        ack_a, rej_a, tflag_a;
  logic [2:0]  cnt_a;

  logic        en_b = 1'b0, kv_b = 1'b0;
  logic [3:0]  kval_b = 4'h0;
  logic [15:0] code_b;
  logic        ack_b, rej_b, tflag_b;
  logic [2:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  int          rej_cnt_a = 0;

  always #5 clk = ~clk;

  keypad_pin_collector #(.ACK_HOLD(2), .TIMEOUT_CYCLES(8), .AUTO_SUBMIT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .entry_enable(en_a), .key_valid(kv_a), .key_value(kval_a),
    .code(code_a), .code_ack(ack_a), .digit_count(cnt_a), .key_reject(rej_a),
    .timeout_flag(tflag_a)
  );

  keypad_pin_collector #(.ACK_HOLD(3), .TIMEOUT_CYCLES(255), .AUTO_SUBMIT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .entry_enable(en_b), .key_valid(kv_b), .key_value(kval_b),
    .code(code_b), .code_ack(ack_b), .digit_count(cnt_b), .key_reject(rej_b),
    .timeout_flag(tflag_b)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Call only at a falling edge; returns one falling edge later.
  task automatic drive(input int which, input logic [3:0] v);
    if (which == 0) begin kv_a = 1'b1; kval_a = v; end
    else            begin kv_b = 1'b1; kval_b = v; end
    @(negedge clk);
    kv_a = 1'b0;
    kv_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitors: pop the expected code on each ack rise, check hold length.
  logic prev_a = 1'b0, prev_b = 1'b0;
  int   len_a = 0, len_b = 0;
  logic [15:0] exp_code;

  always @(negedge clk) begin
    if (rej_a) rej_cnt_a++;
    if (ack_a && !prev_a) begin
      len_a = 0;
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $error("FAIL ack_a_unexpected: observed code %h expected no ack", code_a);
      end else begin
        exp_code = qa.pop_front();
        check("ack_a_code", code_a, exp_code);
      end
    end
    if (ack_a) len_a++;
    else if (prev_a) check("ack_a_len", 16'(len_a), 16'd2);
    prev_a = ack_a;

    if (ack_b && !prev_b) begin
      len_b = 0;
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $error("FAIL ack_b_unexpected: observed code %h expected no ack", code_b);
      end else begin
        exp_code = qb.pop_front();
        check("ack_b_code", code_b, exp_code);
      end
    end
    if (ack_b) len_b++;
    else if (prev_b) check("ack_b_len", 16'(len_b), 16'd3);
    prev_b = ack_b;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int rej_snap;

  initial begin
    // Reset state
    idle(2);
    check("rst_code", code_a, 16'h0000);
    check("rst_ack", 16'(ack_a), 16'd0);
    check("rst_cnt", 16'(cnt_a), 16'd0);
    check("rst_rej", 16'(rej_a), 16'd0);
    check("rst_tflag", 16'(tflag_a), 16'd0);
    rst  = 1'b1;
    en_a = 1'b1;
    idle(1);

    // 1: 2,4,6,8,enter
    qa.push_back(16'h2468);
    drive(0, 4'h2); drive(0, 4'h4); drive(0, 4'h6); drive(0, 4'h8);
    check("t1_cnt4", 16'(cnt_a), 16'd4);
    drive(0, 4'hF);
    check("t1_ack_rise", 16'(ack_a), 16'd1);
    idle(3);
    check("t1_cnt0", 16'(cnt_a), 16'd0);
    check("t1_code_kept", code_a, 16'h2468);

    // 2: clear mid-entry, no rejects
    rej_snap = rej_cnt_a;
    qa.push_back(16'h9999);
    drive(0, 4'h1); drive(0, 4'h2); drive(0, 4'hC);
    check("t2_clr_cnt", 16'(cnt_a), 16'd0);
    drive(0, 4'h9); drive(0, 4'h9); drive(0, 4'h9); drive(0, 4'h9); drive(0, 4'hF);
    idle(3);
    check("t2_no_reject", 16'(rej_cnt_a), 16'(rej_snap));

    // 3: early enter rejected, fifth digit rejected
    drive(0, 4'h1); drive(0, 4'h2); drive(0, 4'hF);
    check("t3_rej_enter", 16'(rej_a), 16'd1);
    check("t3_no_ack", 16'(ack_a), 16'd0);
    check("t3_cnt2", 16'(cnt_a), 16'd2);
    qa.push_back(16'h1234);
    drive(0, 4'h3); drive(0, 4'h4); drive(0, 4'h5);
    check("t3_rej_digit", 16'(rej_a), 16'd1);
    check("t3_code", code_a, 16'h1234);
    drive(0, 4'hF);
    idle(3);

    // 4: timeout after 8 idle cycles, key on the 8th wins
    drive(0, 4'h7);
    idle(7);
    check("t4_no_to_yet", 16'(tflag_a), 16'd0);
    check("t4_cnt1", 16'(cnt_a), 16'd1);
    idle(1);
    check("t4_tflag", 16'(tflag_a), 16'd1);
    check("t4_cnt0", 16'(cnt_a), 16'd0);
    check("t4_code0", code_a, 16'h0000);
    idle(1);
    check("t4_tflag_pulse", 16'(tflag_a), 16'd0);
    drive(0, 4'h7);
    idle(7);
    drive(0, 4'h8);
    check("t4_key_wins_flag", 16'(tflag_a), 16'd0);
    check("t4_key_wins_cnt", 16'(cnt_a), 16'd2);
    check("t4_key_wins_code", code_a, 16'h0078);
    drive(0, 4'hC);

    // entry_enable low in COLLECT discards silently
    drive(0, 4'h3);
    en_a = 1'b0;
    idle(1);
    check("en_low_cnt", 16'(cnt_a), 16'd0);
    check("en_low_code", code_a, 16'h0000);
    check("en_low_rej", 16'(rej_a), 16'd0);
    en_a = 1'b1;

    // 5: auto-submit, ack not truncated by enable drop or keys
    en_b = 1'b1;
    qb.push_back(16'h1357);
    drive(1, 4'h1); drive(1, 4'h3); drive(1, 4'h5); drive(1, 4'h7);
    check("t5_ack_rise", 16'(ack_b), 16'd1);
    check("t5_code", code_b, 16'h1357);
    en_b = 1'b0;
    drive(1, 4'h2);
    check("t5_rej_in_ack", 16'(rej_b), 16'd1);
    check("t5_ack_held", 16'(ack_b), 16'd1);
    idle(3);
    check("t5_cnt0", 16'(cnt_b), 16'd0);
    check("t5_code_kept", code_b, 16'h1357);

    // 6: asynchronous reset mid-entry
    drive(0, 4'h1); drive(0, 4'h2); drive(0, 4'h3);
    check("t6_cnt3", 16'(cnt_a), 16'd3);
    #2 rst = 1'b0;
    #1;
    check("t6_async_code", code_a, 16'h0000);
    check("t6_async_cnt", 16'(cnt_a), 16'd0);
    check("t6_async_ack", 16'(ack_a), 16'd0);
    check("t6_async_rej", 16'(rej_a), 16'd0);
    check("t6_async_tflag", 16'(tflag_a), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 4'h5);
    check("t6_code5", code_a, 16'h0005);
    check("t6_cnt1", 16'(cnt_a), 16'd1);

    idle(2);
    check("qa_drained", 16'(qa.size()), 16'd0);
    check("qb_drained", 16'(qb.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
